// File: rtl/game_sequencer.sv
// Game sequencer: arbitrates gravity and player requests into one outstanding
// board command at a time and tracks the idle / play / over lifecycle.
module game_sequencer #(
   parameter int unsigned BOARD_HEIGHT = 30,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             gravity_tick,
   input  logic             req_left,
   input  logic             req_right,
   input  logic [1:0]       req_rotate,
   input  logic             req_drop,
   input  logic             board_ready,
   input  logic             board_done,
   input  logic             board_blocked,
   output logic [2:0]       cmd,
   output logic             cmd_valid,
   output logic             clear_board,
   output logic             game_over,
   output logic             playing,
   output logic [CNT_W-1:0] pieces_placed
);

   localparam int unsigned FC_W = $clog2(BOARD_HEIGHT + 1);
   localparam int unsigned NP   = 6;

   localparam logic [2:0] CMD_NOP   = 3'd0;
   localparam logic [2:0] CMD_FALL  = 3'd1;
   localparam logic [2:0] CMD_MOVEL = 3'd2;
   localparam logic [2:0] CMD_MOVER = 3'd3;
   localparam logic [2:0] CMD_ROTR  = 3'd4;
   localparam logic [2:0] CMD_ROTL  = 3'd5;
   localparam logic [2:0] CMD_PLACE = 3'd6;
   localparam logic [2:0] CMD_SPAWN = 3'd7;

   localparam int unsigned P_GRAV  = 0;
   localparam int unsigned P_DROP  = 1;
   localparam int unsigned P_ROTR  = 2;
   localparam int unsigned P_ROTL  = 3;
   localparam int unsigned P_LEFT  = 4;
   localparam int unsigned P_RIGHT = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SPAWN,
      S_PLAY,
      S_ISSUE,
      S_WAIT,
      S_PLACE,
      S_OVER
   } state_t;

   state_t          state;
   logic [NP-1:0]   pend;
   logic [NP-1:0]   pend_nxt;
   logic [NP-1:0]   pend_req;
   logic [2:0]      cur_cmd;
   logic [2:0]      sel_cmd;
   logic            drop_mode;
   logic [FC_W-1:0] fall_cnt;
   logic            in_game;
   logic            accept;
   logic            wipe_pend;

   assign pend_req = {req_right, req_left, req_rotate[1], req_rotate[0], req_drop, gravity_tick};
   assign in_game  = state inside {S_SPAWN, S_PLAY, S_ISSUE, S_WAIT, S_PLACE};
   assign accept   = cmd_valid && board_ready;
   // Pending requests are discarded when a piece lands or the game ends.
   assign wipe_pend = (state == S_WAIT) && board_done &&
                      ((cur_cmd == CMD_PLACE) || ((cur_cmd == CMD_SPAWN) && board_blocked));

   // Sticky request bits: clear on acceptance, then absorb new pulses.
   always_comb begin
      pend_nxt = pend;
      if (accept) begin
         case (cur_cmd)
            CMD_FALL: begin
               pend_nxt[P_GRAV] = 1'b0;
               if (drop_mode)
                  pend_nxt[P_DROP] = 1'b0;
            end
            CMD_ROTR:  pend_nxt[P_ROTR]  = 1'b0;
            CMD_ROTL:  pend_nxt[P_ROTL]  = 1'b0;
            CMD_MOVEL: pend_nxt[P_LEFT]  = 1'b0;
            CMD_MOVER: pend_nxt[P_RIGHT] = 1'b0;
            default:   pend_nxt = pend_nxt;
         endcase
      end
      if (wipe_pend)
         pend_nxt = '0;
      pend_nxt = pend_nxt | pend_req;
      if (pend_nxt[P_LEFT] && pend_nxt[P_RIGHT]) begin
         pend_nxt[P_LEFT]  = 1'b0;
         pend_nxt[P_RIGHT] = 1'b0;
      end
      if (!in_game)
         pend_nxt = '0;
   end

   // Fixed-priority pick among pending requests.
   always_comb begin
      sel_cmd = CMD_NOP;
      if (pend[P_DROP])
         sel_cmd = CMD_FALL;
      else if (pend[P_GRAV])
         sel_cmd = CMD_FALL;
      else if (pend[P_ROTR])
         sel_cmd = CMD_ROTR;
      else if (pend[P_ROTL])
         sel_cmd = CMD_ROTL;
      else if (pend[P_LEFT])
         sel_cmd = CMD_MOVEL;
      else if (pend[P_RIGHT])
         sel_cmd = CMD_MOVER;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         pend          <= '0;
         cur_cmd       <= CMD_NOP;
         drop_mode     <= 1'b0;
         fall_cnt      <= '0;
         cmd           <= CMD_NOP;
         cmd_valid     <= 1'b0;
         clear_board   <= 1'b0;
         game_over     <= 1'b0;
         playing       <= 1'b0;
         pieces_placed <= '0;
      end else begin
         pend        <= pend_nxt;
         clear_board <= 1'b0;
         case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  state         <= S_CLEAR;
                  clear_board   <= 1'b1;
                  pieces_placed <= '0;
                  game_over     <= 1'b0;
               end
            end
            S_CLEAR: begin
               state   <= S_SPAWN;
               playing <= 1'b1;
            end
            S_SPAWN: begin
               cmd       <= CMD_SPAWN;
               cmd_valid <= 1'b1;
               cur_cmd   <= CMD_SPAWN;
               state     <= S_ISSUE;
            end
            S_PLAY: begin
               if (sel_cmd != CMD_NOP) begin
                  cmd       <= sel_cmd;
                  cmd_valid <= 1'b1;
                  cur_cmd   <= sel_cmd;
                  state     <= S_ISSUE;
                  if (pend[P_DROP]) begin
                     drop_mode <= 1'b1;
                     fall_cnt  <= FC_W'(1);
                  end
               end
            end
            S_ISSUE: begin
               if (board_ready) begin
                  cmd_valid <= 1'b0;
                  cmd       <= CMD_NOP;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (board_done) begin
                  case (cur_cmd)
                     CMD_SPAWN: begin
                        if (board_blocked) begin
                           state     <= S_OVER;
                           game_over <= 1'b1;
                           playing   <= 1'b0;
                        end else begin
                           state <= S_PLAY;
                        end
                     end
                     CMD_FALL: begin
                        if (board_blocked) begin
                           state     <= S_PLACE;
                           drop_mode <= 1'b0;
                        end else if (drop_mode) begin
                           // Hard drop keeps falling until it lands or hits the board height.
                           if (fall_cnt >= FC_W'(BOARD_HEIGHT)) begin
                              state     <= S_PLACE;
                              drop_mode <= 1'b0;
                           end else begin
                              fall_cnt  <= FC_W'(fall_cnt + 1'b1);
                              cmd       <= CMD_FALL;
                              cmd_valid <= 1'b1;
                              state     <= S_ISSUE;
                           end
                        end else begin
                           state <= S_PLAY;
                        end
                     end
                     CMD_PLACE: begin
                        if (pieces_placed != {CNT_W{1'b1}})
                           pieces_placed <= CNT_W'(pieces_placed + 1'b1);
                        state <= S_SPAWN;
                     end
                     default: state <= S_PLAY;
                  endcase
               end
            end
            S_PLACE: begin
               cmd       <= CMD_PLACE;
               cmd_valid <= 1'b1;
               cur_cmd   <= CMD_PLACE;
               state     <= S_ISSUE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
